// File: rtl/seq_walker_pkg.sv
// Shared helpers for the table-driven sequence walker: index width, step-entry
// layout {out, nxt0, nxt1} (MSB to LSB) and the reset contents of each entry.
package seq_walker_pkg;

    localparam int MAX_STEP_W = 64;

    function automatic int clog2(input int n);
        int w;
        w = 0;
        for (int v = n - 1; v > 0; v = v >> 1) w++;
        return w;
    endfunction

    function automatic int step_w(input int out_w, input int idx_w);
        return out_w + 2 * idx_w;
    endfunction

    // Default graph is a linear wrapping counter: out=i, both successors i+1.
    function automatic logic [MAX_STEP_W-1:0] default_step(input int i, input int n_steps,
                                                           input int out_w, input int idx_w);
        logic [MAX_STEP_W-1:0] o;
        logic [MAX_STEP_W-1:0] nx;
        o  = MAX_STEP_W'(i % (1 << out_w));
        nx = MAX_STEP_W'((i + 1) % n_steps);
        return (o << (2 * idx_w)) | (nx << idx_w) | nx;
    endfunction

endpackage

// File: rtl/seq_step_table.sv
// Step register file: one synchronous write port, a successor read at the current
// index and an output-value read at the next index.
module seq_step_table
    import seq_walker_pkg::*;
#(
    parameter int N_STEPS = 8,
    parameter int OUT_W   = 3,
    parameter int IDX_W   = 3,
    parameter int STEP_W  = OUT_W + 2 * IDX_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [STEP_W-1:0] wr_step,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [STEP_W-1:0] rd_step,
    input  logic [IDX_W-1:0]  out_idx,
    output logic [OUT_W-1:0]  out_val
);

    logic [STEP_W-1:0] tbl_q [N_STEPS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_STEPS; i++) begin
                tbl_q[i] <= STEP_W'(default_step(i, N_STEPS, OUT_W, IDX_W));
            end
        end else if (wr_en && (int'(wr_idx) < N_STEPS)) begin
            tbl_q[wr_idx] <= wr_step;
        end
    end

    always_comb begin
        rd_step = '0;
        if (int'(rd_idx) < N_STEPS) rd_step = tbl_q[rd_idx];
    end

    always_comb begin
        out_val = '0;
        if (int'(out_idx) < N_STEPS) out_val = tbl_q[out_idx][STEP_W-1 -: OUT_W];
    end

endmodule

// File: rtl/seq_walker.sv
// Table-driven sequence walker: index register, successor select with range
// recovery, and the registered saida/hit/err outputs.
module seq_walker
    import seq_walker_pkg::*;
#(
    parameter int N_STEPS   = 8,
    parameter int OUT_W     = 3,
    parameter int START_IDX = 0,
    parameter int TERM_IDX  = N_STEPS - 1,
    localparam int IDX_W    = clog2(N_STEPS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             adv,
    input  logic             a,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [OUT_W-1:0] wr_out,
    input  logic [IDX_W-1:0] wr_nxt0,
    input  logic [IDX_W-1:0] wr_nxt1,
    output logic [IDX_W-1:0] cur_idx,
    output logic [OUT_W-1:0] saida,
    output logic             hit,
    output logic             err
);

    localparam int STEP_W = step_w(OUT_W, IDX_W);

    logic [IDX_W-1:0]  cur_idx_q, cur_idx_d;
    logic [OUT_W-1:0]  saida_q, saida_d;
    logic              hit_q, hit_d;
    logic              err_q, err_d;
    logic [STEP_W-1:0] cur_step;
    logic [IDX_W-1:0]  nxt;
    logic              nxt_legal;

    seq_step_table #(
        .N_STEPS (N_STEPS),
        .OUT_W   (OUT_W),
        .IDX_W   (IDX_W),
        .STEP_W  (STEP_W)
    ) u_table (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_step ({wr_out, wr_nxt0, wr_nxt1}),
        .rd_idx  (cur_idx_q),
        .rd_step (cur_step),
        .out_idx (cur_idx_d),
        .out_val (saida_d)
    );

    assign nxt       = a ? cur_step[IDX_W-1:0] : cur_step[2*IDX_W-1 -: IDX_W];
    assign nxt_legal = int'(nxt) < N_STEPS;

    always_comb begin
        cur_idx_d = cur_idx_q;
        err_d     = 1'b0;
        if (adv) begin
            if (nxt_legal) begin
                cur_idx_d = nxt;
            end else begin
                cur_idx_d = IDX_W'(START_IDX);
                err_d     = 1'b1;
            end
        end
        hit_d = adv && (cur_idx_d == IDX_W'(TERM_IDX));
    end

    // saida_d reads the table before this edge's write lands, so same-edge
    // writes show up one edge later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_idx_q <= IDX_W'(START_IDX);
            saida_q   <= OUT_W'(START_IDX);
            hit_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            cur_idx_q <= cur_idx_d;
            saida_q   <= saida_d;
            hit_q     <= hit_d;
            err_q     <= err_d;
        end
    end

    assign cur_idx = cur_idx_q;
    assign saida   = saida_q;
    assign hit     = hit_q;
    assign err     = err_q;

endmodule

// File: tb/tb_seq_walker.sv
// Directed bench for seq_walker: default 8-step instance plus a 5-step instance
// for out-of-range successor recovery.
module tb_seq_walker;

    logic       clk;
    logic       reset;
    logic       adv;
    logic       a;
    logic       wr_en;
    logic [2:0] wr_idx;
    logic [2:0] wr_out;
    logic [2:0] wr_nxt0;
    logic [2:0] wr_nxt1;

    logic [2:0] cur8, saida8, cur5, saida5;
    logic       hit8, err8, hit5, err5;

    int errors = 0;
    int checks = 0;

    seq_walker u_dut8 (
        .clk(clk), .reset(reset), .adv(adv), .a(a),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_out(wr_out), .wr_nxt0(wr_nxt0), .wr_nxt1(wr_nxt1),
        .cur_idx(cur8), .saida(saida8), .hit(hit8), .err(err8)
    );

    seq_walker #(.N_STEPS(5)) u_dut5 (
        .clk(clk), .reset(reset), .adv(adv), .a(a),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_out(wr_out), .wr_nxt0(wr_nxt0), .wr_nxt1(wr_nxt1),
        .cur_idx(cur5), .saida(saida5), .hit(hit5), .err(err5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk8(input string tag, input int idx, input int sd, input int h, input int e);
        chk({tag, ".cur"},   int'(cur8),   idx);
        chk({tag, ".saida"}, int'(saida8), sd);
        chk({tag, ".hit"},   int'(hit8),   h);
        chk({tag, ".err"},   int'(err8),   e);
    endtask

    task automatic wr(input int idx, input int o, input int n0, input int n1);
        wr_en   = 1'b1;
        wr_idx  = 3'(idx);
        wr_out  = 3'(o);
        wr_nxt0 = 3'(n0);
        wr_nxt1 = 3'(n1);
    endtask

    task automatic pulse_reset();
        #2;
        reset = 1'b0;
        #1;
        tick();
        reset = 1'b1;
    endtask

    int prog [5][3] = '{'{2, 1, 1}, '{6, 3, 2}, '{4, 3, 3}, '{0, 0, 4}, '{1, 0, 0}};
    // a, expected cur_idx, expected saida
    int walk [8][3] = '{'{0, 1, 6}, '{0, 3, 0}, '{0, 0, 2}, '{0, 1, 6},
                        '{1, 2, 4}, '{1, 3, 0}, '{1, 4, 1}, '{1, 0, 2}};

    initial begin
        reset = 1'b0; adv = 1'b0; a = 1'b0;
        wr_en = 1'b0; wr_idx = '0; wr_out = '0; wr_nxt0 = '0; wr_nxt1 = '0;
        tick();
        tick();
        chk8("rst", 0, 0, 0, 0);
        chk("rst5.cur", int'(cur5), 0);
        reset = 1'b1;

        // defaults: linear wrapping counter
        adv = 1'b1; a = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk8($sformatf("dflt%0d", k), k % 8, k % 8, (k % 8 == 7) ? 1 : 0, 0);
            chk($sformatf("dflt5_%0d.cur", k), int'(cur5), k % 5);
            chk($sformatf("dflt5_%0d.hit", k), int'(hit5), (k % 5 == 4) ? 1 : 0);
        end

        // program a branching graph while parked at step 0
        adv = 1'b0;
        pulse_reset();
        for (int i = 0; i < 5; i++) begin
            wr(i, prog[i][0], prog[i][1], prog[i][2]);
            tick();
        end
        wr_en = 1'b0;
        tick();
        chk8("prog.park", 0, 2, 0, 0);

        adv = 1'b1;
        for (int k = 0; k < 8; k++) begin
            a = walk[k][0][0];
            tick();
            chk8($sformatf("walk%0d", k), walk[k][1], walk[k][2], 0, 0);
        end

        // adv low holds everything
        a = 1'b0;
        tick();
        chk8("hold.pre", 1, 6, 0, 0);
        adv = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk8($sformatf("hold%0d", k), 1, 6, 0, 0);
        end

        // same-edge write to current step
        adv = 1'b1;
        tick();
        chk8("sw.at3", 3, 0, 0, 0);
        adv = 1'b0;
        wr(3, 5, 0, 4);
        tick();
        chk8("sw.wedge", 3, 0, 0, 0);
        wr_en = 1'b0;
        tick();
        chk8("sw.after", 3, 5, 0, 0);
        adv = 1'b1; a = 1'b0;
        wr(3, 5, 4, 4);
        tick();
        chk8("sw.advold", 0, 2, 0, 0);
        wr_en = 1'b0;
        tick();
        chk8("sw.to1", 1, 6, 0, 0);
        tick();
        chk8("sw.to3", 3, 5, 0, 0);
        tick();
        chk8("sw.newnxt", 4, 1, 0, 0);

        // terminal step entry and self-loop
        adv = 1'b0;
        wr(4, 1, 7, 7);
        tick();
        wr(7, 7, 7, 0);
        tick();
        wr_en = 1'b0;
        adv = 1'b1; a = 1'b0;
        tick();
        chk8("term.enter", 7, 7, 1, 0);
        tick();
        chk8("term.self", 7, 7, 1, 0);
        adv = 1'b0;
        tick();
        chk8("term.hold", 7, 7, 0, 0);
        adv = 1'b1; a = 1'b1;
        tick();
        chk8("term.exit", 0, 2, 0, 0);

        // async reset mid-walk restores defaults
        a = 1'b0;
        tick();
        chk8("mr.pre", 1, 6, 0, 0);
        #2;
        reset = 1'b0;
        #1;
        chk8("mr.async", 0, 0, 0, 0);
        tick();
        chk8("mr.held", 0, 0, 0, 0);
        reset = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk8($sformatf("mr.dflt%0d", k), k, k, (k == 7) ? 1 : 0, 0);
        end

        // 5-step instance: illegal successor and ignored out-of-range write
        adv = 1'b0;
        pulse_reset();
        wr(2, 2, 6, 3);
        tick();
        wr(7, 5, 1, 1);
        tick();
        wr_en = 1'b0;
        chk("ill.park", int'(cur5), 0);
        adv = 1'b1; a = 1'b0;
        tick();
        chk("ill.s1.cur", int'(cur5), 1);
        chk("ill.s1.saida", int'(saida5), 1);
        chk("ill.s1.err", int'(err5), 0);
        tick();
        chk("ill.s2.cur", int'(cur5), 2);
        chk("ill.s2.saida", int'(saida5), 2);
        tick();
        chk("ill.rec.cur", int'(cur5), 0);
        chk("ill.rec.saida", int'(saida5), 0);
        chk("ill.rec.err", int'(err5), 1);
        chk("ill.rec.hit", int'(hit5), 0);
        adv = 1'b0;
        tick();
        chk("ill.after.err", int'(err5), 0);
        chk("ill.after.cur", int'(cur5), 0);
        adv = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            tick();
            chk($sformatf("ill.dflt%0d.saida", k), int'(saida5), k);
            chk($sformatf("ill.dflt%0d.err", k), int'(err5), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
